regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the next-generation pipelined CPU core. Replaces the fixed 2-read/1-write, negedge-written register file.
- Writes occur on the rising edge. Same-cycle write-to-read visibility comes from an internal combinational bypass instead of half-cycle timing.
- Adds multiple write ports with fixed priority, synchronous clear, and a per-register pending-write scoreboard. Decode uses the scoreboard for hazard stalls.

Parameters:
- DW, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥2)
- AW, 5, address width; must equal log2(NREG)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- we  in  NWR  write enable per write port
- wa  in  NWR*AW  write addresses, port i at bits [i*AW +: AW]
- wd  in  NWR*DW  write data, port i at bits [i*DW +: DW]
- ra  in  NRD*AW  read addresses, port j at bits [j*AW +: AW]
- rd  out  NRD*DW  read data, port j at bits [j*DW +: DW], combinational
- mark_en  in  1  set pending-write flag for mark_addr (instruction issued with a destination)
- mark_addr  in  AW  register to mark busy
- busy  out  NRD  per read port: source register has an outstanding write not yet visible

Behaviour:
- Reset: on a rising edge with rst=1, all NREG registers clear to 0 and all busy flags clear. In that cycle we and mark_en are ignored and the bypass is disabled (rd shows stored values, busy shows stored flags). Reset asserted mid-stream discards any in-flight writes. From the first edge after reset deassertion, rd=0 and busy=0 on every port.
- Write: on a rising edge with rst=0, for each i with we[i]=1, rf[wa[i]] <= wd[i].
  - If several enabled ports share an address, the highest index i wins.
  - With ZERO_REG=1, writes to address 0 are discarded.
  - Latency: stored value readable from the stored path one cycle after the write edge.
- Read: rd[j] is purely combinational from ra[j].
  - With ZERO_REG=1 and ra[j]=0, rd[j]=0 regardless of writes or bypass.
  - Else, if BYPASS=1, rst=0, and some we[i]=1 with wa[i]=ra[j], rd[j] = wd of the highest such i.
  - Else rd[j] = rf[ra[j]].
  - Reads on different ports are independent; the same address on all ports returns identical data.
- Scoreboard: one flag per register, updated on the rising edge (rst=0).
  - Clear: flag[wa[i]] <= 0 for every enabled write port.
  - Set: mark_en=1 sets flag[mark_addr] <= 1.
  - Same address marked and written in the same cycle: set wins, because the mark belongs to a newer producer.
  - With ZERO_REG=1, marks to address 0 are ignored and flag[0] is constant 0.
- busy output: busy[j] = flag[ra[j]], AND-ed with "no enabled write to ra[j] this cycle" when BYPASS=1 and rst=0.
  - A mark this cycle does not affect busy until the next edge.
  - With ZERO_REG=1 and ra[j]=0, busy[j]=0.
- Width rules:
  - Addresses ≥ NREG cannot occur (AW = log2 NREG).
  - No sign extension or truncation; data passes through at exactly DW bits.
- Implementation constraints: no initial blocks and no negedge logic. Storage must be implementable as flops, because synchronous clear of all entries is required.

Test Plan:
- Reset: preload r5=0x1234 via port 0, pulse rst for 1 cycle → after the edge, rd for ra=5 is 0x00000000 and busy=0. A we=1 to r6 asserted during rst leaves r6=0.
- Bypass and priority: same cycle we=2'b11, wa0=wa1=7, wd0=0xAAAA0000, wd1=0x5555FFFF, ra0=ra1=7 → rd0=rd1=0x5555FFFF combinationally; next cycle, with we=0, rd=0x5555FFFF.
- BYPASS=0 build: write r3=0xDEADBEEF while ra0=3 → rd0 shows the old value 0 that cycle and 0xDEADBEEF the cycle after.
- Zero register: we0=1, wa0=0, wd0=0xFFFFFFFF, mark_en=1, mark_addr=0 → rd for ra=0 stays 0 and busy=0 that cycle and the next.
- Scoreboard: mark r9 at cycle t → busy=1 from t+1 for ra=9. Write r9=0x42 at t+3 → busy=0 combinationally at t+3 and rd=0x42. Flag is clear at t+4.
- Mark/write collision: r4 busy from an earlier mark; at t, write r4 and mark r4 together → from t+1, busy=1 and rd(4) equals the written data.

Source files
------------

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_if
//  Purpose  : Write, read and scoreboard-mark bundle for the multi-port
//             register file.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_mp_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2,
    parameter int NWR = 2
);
    logic [NWR-1:0]    we;
    logic [NWR*AW-1:0] wa;
    logic [NWR*DW-1:0] wd;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic              mark_en;
    logic [AW-1:0]     mark_addr;
    logic [NRD-1:0]    busy;

    modport master (
        output we, wa, wd, ra, mark_en, mark_addr,
        input  rd, busy
    );

    modport slave (
        input  we, wa, wd, ra, mark_en, mark_addr,
        output rd, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Parametrised multi-port register file with fixed-priority
//             writes, same-cycle bypass and a pending-write scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    regfile_mp_if.slave     bus
);

    logic [DW-1:0]     r_rf [NREG];
    logic [NREG-1:0]   r_flag;

    logic [AW-1:0]     w_ra [NRD];
    logic [NRD*DW-1:0] w_rd;
    logic [NRD-1:0]    w_busy;

    for (genvar j = 0; j < NRD; j++) begin : g_ra
        assign w_ra[j] = bus.ra[j*AW +: AW];
    end

    // Loops run in ascending port order so the highest enabled port's
    // assignment lands last; the mark is applied after the write-clears so
    // a newer producer's mark overrides a retiring write to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_rf[k] <= '0;
            end
            r_flag <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (bus.we[i] && !(ZERO_REG != 0 && bus.wa[i*AW +: AW] == '0)) begin
                    r_rf[bus.wa[i*AW +: AW]] <= bus.wd[i*DW +: DW];
                end
            end
            for (int i = 0; i < NWR; i++) begin
                if (bus.we[i]) begin
                    r_flag[bus.wa[i*AW +: AW]] <= 1'b0;
                end
            end
            if (bus.mark_en && !(ZERO_REG != 0 && bus.mark_addr == '0)) begin
                r_flag[bus.mark_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd   = '0;
        w_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            w_rd[j*DW +: DW] = r_rf[w_ra[j]];
            w_busy[j]        = r_flag[w_ra[j]];
            if (BYPASS != 0 && !rst) begin
                for (int i = 0; i < NWR; i++) begin
                    if (bus.we[i] && bus.wa[i*AW +: AW] == w_ra[j]) begin
                        w_rd[j*DW +: DW] = bus.wd[i*DW +: DW];
                        w_busy[j]        = 1'b0;
                    end
                end
            end
            if (ZERO_REG != 0 && w_ra[j] == '0) begin
                w_rd[j*DW +: DW] = '0;
                w_busy[j]        = 1'b0;
            end
        end
    end

    assign bus.rd   = w_rd;
    assign bus.busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp, bypass and no-bypass builds
//             driven in lockstep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic        mark_en;
    logic [4:0]  mark_addr;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp_if #(.DW(32), .AW(5), .NRD(2), .NWR(2)) bus1 ();
    regfile_mp_if #(.DW(32), .AW(5), .NRD(2), .NWR(2)) bus0 ();

    assign bus1.we = we;  assign bus1.wa = wa;  assign bus1.wd = wd;
    assign bus1.ra = ra;  assign bus1.mark_en = mark_en;  assign bus1.mark_addr = mark_addr;
    assign bus0.we = we;  assign bus0.wa = wa;  assign bus0.wd = wd;
    assign bus0.ra = ra;  assign bus0.mark_en = mark_en;  assign bus0.mark_addr = mark_addr;

    regfile_mp #(.DW(32), .NREG(32), .AW(5), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    regfile_mp #(.DW(32), .NREG(32), .AW(5), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: plain arrays, updated from the architectural rules.
    logic [31:0] mrf [32];
    bit   [31:0] mflag;

    function automatic logic [31:0] m_rd(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (byp && !rst)
            for (int i = 1; i >= 0; i--)
                if (we[i] && wa[i*5 +: 5] == a) return wd[i*32 +: 32];
        return mrf[a];
    endfunction

    function automatic logic m_busy(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (byp && !rst)
            for (int i = 0; i < 2; i++)
                if (we[i] && wa[i*5 +: 5] == a) return 1'b0;
        return mflag[a];
    endfunction

    task automatic m_update();
        if (rst) begin
            for (int a = 0; a < 32; a++) mrf[a] = 32'h0;
            mflag = '0;
        end else begin
            for (int a = 1; a < 32; a++) begin
                for (int i = 1; i >= 0; i--) begin
                    if (we[i] && wa[i*5 +: 5] == a[4:0]) begin
                        mrf[a] = wd[i*32 +: 32];
                        break;
                    end
                end
                if ((we[0] && wa[4:0] == a[4:0]) || (we[1] && wa[9:5] == a[4:0])) mflag[a] = 1'b0;
                if (mark_en && mark_addr == a[4:0]) mflag[a] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          chk;
        logic        rst;
        logic [1:0]  we;
        logic [9:0]  wa;
        logic [63:0] wd;
        logic [9:0]  ra;
        logic        me;
        logic [4:0]  ma;
        logic [63:0] e1rd;
        logic [1:0]  e1b;
        logic [63:0] e0rd;
        logic [1:0]  e0b;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit c, input logic r, input logic [1:0] w,
                       input logic [4:0] wa1, input logic [4:0] wa0,
                       input logic [31:0] wd1, input logic [31:0] wd0,
                       input logic [4:0] ra1, input logic [4:0] ra0,
                       input logic me, input logic [4:0] ma,
                       input logic [31:0] e1r1, input logic [31:0] e1r0, input logic [1:0] e1b,
                       input logic [31:0] e0r1, input logic [31:0] e0r0, input logic [1:0] e0b);
        vec_t v;
        v.chk = c;  v.rst = r;  v.we = w;
        v.wa = {wa1, wa0};  v.wd = {wd1, wd0};  v.ra = {ra1, ra0};
        v.me = me;  v.ma = ma;
        v.e1rd = {e1r1, e1r0};  v.e1b = e1b;
        v.e0rd = {e0r1, e0r0};  v.e0b = e0b;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    initial begin
        rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; mark_en = 1'b0; mark_addr = '0;
        for (int a = 0; a < 32; a++) mrf[a] = 32'h0;
        mflag = '0;

        //  chk rst we  wa1 wa0 wd1           wd0           ra1 ra0 me ma  byp rd1/rd0/busy                     nobyp rd1/rd0/busy
        add(0, 1, 2'b00, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         5, 5, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00);
        add(1, 0, 2'b01, 0, 5, 32'h0,        32'h1234,      5, 5, 0, 0, 32'h1234,     32'h1234,     2'b00, 32'h0,        32'h0,        2'b00);
        add(1, 1, 2'b10, 6, 0, 32'h77,       32'h0,         6, 5, 0, 0, 32'h0,        32'h1234,     2'b00, 32'h0,        32'h1234,     2'b00);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         6, 5, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00);
        add(1, 0, 2'b11, 7, 7, 32'h5555FFFF, 32'hAAAA0000,  7, 7, 0, 0, 32'h5555FFFF, 32'h5555FFFF, 2'b00, 32'h0,        32'h0,        2'b00);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         7, 7, 0, 0, 32'h5555FFFF, 32'h5555FFFF, 2'b00, 32'h5555FFFF, 32'h5555FFFF, 2'b00);
        add(1, 0, 2'b01, 0, 3, 32'h0,        32'hDEADBEEF,  7, 3, 0, 0, 32'h5555FFFF, 32'hDEADBEEF, 2'b00, 32'h5555FFFF, 32'h0,        2'b00);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         7, 3, 0, 0, 32'h5555FFFF, 32'hDEADBEEF, 2'b00, 32'h5555FFFF, 32'hDEADBEEF, 2'b00);
        add(1, 0, 2'b01, 0, 0, 32'h0,        32'hFFFFFFFF,  0, 0, 1, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         9, 9, 1, 9, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         9, 9, 0, 0, 32'h0,        32'h0,        2'b11, 32'h0,        32'h0,        2'b11);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         9, 9, 0, 0, 32'h0,        32'h0,        2'b11, 32'h0,        32'h0,        2'b11);
        add(1, 0, 2'b01, 0, 9, 32'h0,        32'h42,        9, 9, 0, 0, 32'h42,       32'h42,       2'b00, 32'h0,        32'h0,        2'b11);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         9, 9, 0, 0, 32'h42,       32'h42,       2'b00, 32'h42,       32'h42,       2'b00);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         9, 4, 1, 4, 32'h42,       32'h0,        2'b00, 32'h42,       32'h0,        2'b00);
        add(1, 0, 2'b10, 4, 0, 32'hCAFE0004, 32'h0,         4, 4, 1, 4, 32'hCAFE0004, 32'hCAFE0004, 2'b00, 32'h0,        32'h0,        2'b11);
        add(1, 0, 2'b00, 0, 0, 32'h0,        32'h0,         4, 4, 0, 0, 32'hCAFE0004, 32'hCAFE0004, 2'b11, 32'hCAFE0004, 32'hCAFE0004, 2'b11);

        @(posedge clk);
        #1;
        for (int k = 0; k < vq.size(); k++) begin
            rst = vq[k].rst;  we = vq[k].we;  wa = vq[k].wa;  wd = vq[k].wd;
            ra = vq[k].ra;  mark_en = vq[k].me;  mark_addr = vq[k].ma;
            @(negedge clk);
            if (vq[k].chk) begin
                for (int j = 0; j < 2; j++) begin
                    chk($sformatf("vec%0d byp rd%0d", k, j), bus1.rd[j*32 +: 32], vq[k].e1rd[j*32 +: 32]);
                    chk($sformatf("vec%0d byp busy%0d", k, j), {31'b0, bus1.busy[j]}, {31'b0, vq[k].e1b[j]});
                    chk($sformatf("vec%0d nobyp rd%0d", k, j), bus0.rd[j*32 +: 32], vq[k].e0rd[j*32 +: 32]);
                    chk($sformatf("vec%0d nobyp busy%0d", k, j), {31'b0, bus0.busy[j]}, {31'b0, vq[k].e0b[j]});
                end
            end
            tick();
        end

        // Random traffic on a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            we        = 2'($urandom_range(0, 3));
            wa        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wd        = {$urandom, $urandom};
            ra        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            mark_en   = ($urandom_range(0, 2) == 0);
            mark_addr = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                wa = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
                ra = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            end
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("rnd%0d byp rd%0d", n, j), bus1.rd[j*32 +: 32], m_rd(1'b1, ra[j*5 +: 5]));
                chk($sformatf("rnd%0d byp busy%0d", n, j), {31'b0, bus1.busy[j]}, {31'b0, m_busy(1'b1, ra[j*5 +: 5])});
                chk($sformatf("rnd%0d nobyp rd%0d", n, j), bus0.rd[j*32 +: 32], m_rd(1'b0, ra[j*5 +: 5]));
                chk($sformatf("rnd%0d nobyp busy%0d", n, j), {31'b0, bus0.busy[j]}, {31'b0, m_busy(1'b0, ra[j*5 +: 5])});
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
